trig_readout_scheduler: RTL and testbench



---
 rtl/trig_readout_scheduler_if.sv | 29 ++
 rtl/trig_readout_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_trig_readout_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_readout_scheduler_if.sv
// Trigger-side and readout-side signal bundle for trig_readout_scheduler.
//
// Handshake semantics (readout side): a transfer happens on every rising aclk
// edge where m_valid_o and m_ready_i are both high. While m_valid_o is high
// and m_ready_i is low, m_trig_time_o and m_event_no_o are held stable and
// m_valid_o stays high. trig_valid_i is a one-cycle strobe with no
// backpressure: a trigger not accepted in its cycle is lost (and counted).
interface trig_readout_scheduler_if #(
   parameter int TIMEBITS = 16
);
   logic [TIMEBITS-1:0] trig_time_i;
   logic                trig_valid_i;
   logic [TIMEBITS-1:0] m_trig_time_o;
   logic [15:0]         m_event_no_o;
   logic                m_valid_o;
   logic                m_ready_i;

   // The scheduler: consumes triggers, produces readout requests.
   modport slave (
      input  trig_time_i, trig_valid_i, m_ready_i,
      output m_trig_time_o, m_event_no_o, m_valid_o
   );

   // The environment: produces triggers, consumes readout requests.
   modport master (
      output trig_time_i, trig_valid_i, m_ready_i,
      input  m_trig_time_o, m_event_no_o, m_valid_o
   );
endinterface

// File: rtl/trig_readout_scheduler.sv
// Trigger readout scheduler (aclk domain).
// Accepts triggers while a run is active, enforcing a minimum spacing between
// accepted triggers and a free event-buffer credit per trigger, tags each one
// with an event number and hands it to the URAM address path over valid/ready.
// Refused triggers during a run are counted; buffers return credits via
// buf_done_i.
// Optional: define TRIG_SCHED_DEADTIME_EN to add deadtime_o, a saturating count
// of RUN cycles spent credit-starved or in holdoff.
module trig_readout_scheduler #(
   parameter int NBUF     = 4,
   parameter int HOLDOFF  = 32,
   parameter int TIMEBITS = 16,
   parameter int CNTBITS  = 16
) (
   input  logic                        aclk_i,
   input  logic                        aclk_rst_i,
   input  logic                        run_rst_i,
   input  logic                        run_stop_i,
   trig_readout_scheduler_if.slave     bus,
   input  logic                        buf_done_i,
   output logic [$clog2(NBUF+1)-1:0]   credits_o,
   output logic [CNTBITS-1:0]          drop_count_o,
   output logic                        running_o,
   output logic                        stopped_o,
   output logic                        err_o,
   output logic [1:0]                  state_o
`ifdef TRIG_SCHED_DEADTIME_EN
   ,
   output logic [31:0]                 deadtime_o
`endif
);

   localparam int CW = $clog2(NBUF + 1);
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [CW-1:0] NBUF_C    = CW'(NBUF);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state;
   logic [CW-1:0]       credits;
   logic [HW-1:0]       holdoff;
   logic [15:0]         event_no;
   logic [TIMEBITS-1:0] time_q;
   logic [15:0]         event_q;
   logic                valid_q;

   logic                out_free;
   logic                accept;
   logic                drop;
   logic                run_clr;
   logic [15:0]         event_cur;

   assign state_o           = state;
   assign credits_o         = credits;
   assign bus.m_trig_time_o = time_q;
   assign bus.m_event_no_o  = event_q;
   assign bus.m_valid_o     = valid_q;

   // The output register can take a new request when empty or being drained.
   assign out_free = !valid_q || bus.m_ready_i;

   // A stop in the same cycle as a trigger always refuses it.
   assign accept = bus.trig_valid_i && (state == S_RUN) && !run_stop_i &&
                   (credits != '0) && (holdoff == '0) && out_free;

   assign drop = bus.trig_valid_i && (state == S_RUN) && !accept;

   // Run-start clears counters; a simultaneous stop wins and suppresses it.
   assign run_clr = run_rst_i &&
                    ((state == S_IDLE) || ((state == S_RUN) && !run_stop_i));

   // A trigger accepted together with a run restart is the first of the new run.
   assign event_cur = run_clr ? 16'd0 : event_no;

   // Run-state machine with registered status flags.
   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) begin
         state     <= S_IDLE;
         running_o <= 1'b0;
         stopped_o <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (run_rst_i) begin
                  state     <= S_RUN;
                  running_o <= 1'b1;
                  stopped_o <= 1'b0;
               end
            end
            S_RUN: begin
               if (run_stop_i) begin
                  state     <= S_DRAIN;
                  running_o <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (!valid_q && (credits == NBUF_C)) begin
                  state     <= S_IDLE;
                  stopped_o <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               running_o <= 1'b0;
               stopped_o <= 1'b1;
            end
         endcase
      end
   end

   // Readout request register: load on accept, hold until handshake.
   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) begin
         valid_q <= 1'b0;
         time_q  <= '0;
         event_q <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         time_q  <= bus.trig_time_i;
         event_q <= event_cur;
      end else if (bus.m_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   // Event numbering and saturating drop counter for the current run.
   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) begin
         event_no     <= '0;
         drop_count_o <= '0;
      end else begin
         if (accept) begin
            event_no <= event_cur + 16'd1;
         end else if (run_clr) begin
            event_no <= 16'd0;
         end

         if (run_clr) begin
            drop_count_o <= {{(CNTBITS-1){1'b0}}, drop};
         end else if (drop && (drop_count_o != {CNTBITS{1'b1}})) begin
            drop_count_o <= drop_count_o + CNTBITS'(1);
         end
      end
   end

   // Trigger spacing: loaded on accept, counts down to zero.
   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) begin
         holdoff <= '0;
      end else if ((state == S_IDLE) && run_rst_i) begin
         holdoff <= '0;
      end else if (accept) begin
         holdoff <= HOLD_LOAD;
      end else if (holdoff != '0) begin
         holdoff <= holdoff - HW'(1);
      end
   end

   // Buffer credits and sticky overflow error (release with all buffers free).
   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) begin
         credits <= NBUF_C;
         err_o   <= 1'b0;
      end else if (accept && !buf_done_i) begin
         credits <= credits - CW'(1);
      end else if (buf_done_i && !accept) begin
         if (credits == NBUF_C) begin
            err_o <= 1'b1;
         end else begin
            credits <= credits + CW'(1);
         end
      end
   end

`ifdef TRIG_SCHED_DEADTIME_EN
   // Deadtime: RUN cycles where no trigger could be taken for lack of credit or spacing.
   always_ff @(posedge aclk_i) begin
      if (aclk_rst_i) begin
         deadtime_o <= '0;
      end else if (run_clr) begin
         deadtime_o <= '0;
      end else if ((state == S_RUN) && ((credits == '0) || (holdoff != '0)) &&
                   (deadtime_o != 32'hFFFF_FFFF)) begin
         deadtime_o <= deadtime_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_trig_readout_scheduler.sv
// Directed testbench for trig_readout_scheduler (NBUF=4, HOLDOFF=32).
// A cycle-stamped behavioural model predicts every output; a compare process
// checks it on each falling edge, a scoreboard queue checks every transfer,
// and literal expectations pin the key scenario results.
module tb_trig_readout_scheduler;

   localparam int NBUF     = 4;
   localparam int HOLDOFF  = 32;
   localparam int TIMEBITS = 16;
   localparam int CNTBITS  = 16;
   localparam int CW       = $clog2(NBUF + 1);

   // ---------------- clock / reset / DUT ----------------
   logic aclk = 1'b0;
   logic aclk_rst = 1'b0;
   logic run_rst = 1'b0;
   logic run_stop = 1'b0;
   logic buf_done = 1'b0;
   logic [CW-1:0]      credits;
   logic [CNTBITS-1:0] drop_count;
   logic running, stopped, err;
   logic [1:0] state_dbg;
`ifdef TRIG_SCHED_DEADTIME_EN
   logic [31:0] deadtime;
`endif

   bit rdy = 1'b1;
   bit rst_req = 1'b0;

   trig_readout_scheduler_if #(.TIMEBITS(TIMEBITS)) bus();

   trig_readout_scheduler #(
      .NBUF(NBUF), .HOLDOFF(HOLDOFF), .TIMEBITS(TIMEBITS), .CNTBITS(CNTBITS)
   ) dut (
      .aclk_i       (aclk),
      .aclk_rst_i   (aclk_rst),
      .run_rst_i    (run_rst),
      .run_stop_i   (run_stop),
      .bus          (bus),
      .buf_done_i   (buf_done),
      .credits_o    (credits),
      .drop_count_o (drop_count),
      .running_o    (running),
      .stopped_o    (stopped),
      .err_o        (err),
      .state_o      (state_dbg)
`ifdef TRIG_SCHED_DEADTIME_EN
      ,
      .deadtime_o   (deadtime)
`endif
   );

   always #5 aclk = ~aclk;

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Modes: 0 idle, 1 run, 2 drain (same numbering as the debug state output).
   bit     started = 1'b0;
   longint cyc = 0;
   longint m_last;          // cycle stamp of the last accepted trigger
   int     m_mode, m_credits, m_ev, m_dc, m_time, m_evout;
   bit     m_valid, m_err;
   bit     acc, drp, clr, hold_ok, o_valid;
   int     o_cred;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   always @(posedge aclk) begin
      cyc = cyc + 1;
      // Scoreboard: each DUT transfer must match the oldest predicted request.
      if (started && !aclk_rst && bus.m_valid_o === 1'b1 && bus.m_ready_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("xfer_without_accept", bus.m_valid_o, 0);
         end else begin
            e = exp_q.pop_front();
            check("xfer_time", bus.m_trig_time_o, e[31:16]);
            check("xfer_event", bus.m_event_no_o, e[15:0]);
         end
      end

      if (aclk_rst) begin
         started   = 1'b1;
         m_mode    = 0;
         m_credits = NBUF;
         m_ev      = 0;
         m_dc      = 0;
         m_time    = 0;
         m_evout   = 0;
         m_valid   = 1'b0;
         m_err     = 1'b0;
         m_last    = -1000;
         exp_q.delete();
      end else if (started) begin
         o_valid = m_valid;
         o_cred  = m_credits;
         hold_ok = (cyc - m_last) >= HOLDOFF;
         acc = bus.trig_valid_i && (m_mode == 1) && !run_stop && (m_credits > 0) &&
               hold_ok && (!m_valid || bus.m_ready_i);
         drp = bus.trig_valid_i && (m_mode == 1) && !acc;
         clr = run_rst && ((m_mode == 0) || ((m_mode == 1) && !run_stop));

         if (acc) begin
            m_valid = 1'b1;
            m_time  = bus.trig_time_i;
            m_evout = clr ? 0 : m_ev;
            m_ev    = (m_evout + 1) % 65536;
            m_last  = cyc;
            exp_q.push_back({m_time[15:0], m_evout[15:0]});
         end else begin
            if (bus.m_ready_i) m_valid = 1'b0;
            if (clr) m_ev = 0;
         end

         if (clr) m_dc = drp ? 1 : 0;
         else if (drp && m_dc < (2**CNTBITS - 1)) m_dc = m_dc + 1;

         if (acc && !buf_done) m_credits = m_credits - 1;
         else if (buf_done && !acc) begin
            if (m_credits == NBUF) m_err = 1'b1;
            else m_credits = m_credits + 1;
         end

         case (m_mode)
            0: if (run_rst) begin m_mode = 1; m_last = -1000; end
            1: if (run_stop) m_mode = 2;
            default: if (!o_valid && o_cred == NBUF) m_mode = 0;
         endcase
      end
   end

   // Compare process: every output, every cycle, away from the active edge.
   always @(negedge aclk) begin
      if (started) begin
         check("m_valid", bus.m_valid_o, m_valid);
         check("m_trig_time", bus.m_trig_time_o, m_time);
         check("m_event_no", bus.m_event_no_o, m_evout);
         check("credits", credits, m_credits);
         check("drop_count", drop_count, m_dc);
         check("running", running, m_mode == 1);
         check("stopped", stopped, m_mode == 0);
         check("err", err, m_err);
         check("state", state_dbg, m_mode);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input bit tv, input logic [15:0] tt, input bit rr, input bit rs, input bit bd);
      @(negedge aclk);
      aclk_rst         = rst_req;
      bus.trig_valid_i = tv;
      bus.trig_time_i  = tt;
      run_rst          = rr;
      run_stop         = rs;
      buf_done         = bd;
      bus.m_ready_i    = rdy;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic trig(input logic [15:0] tt);
      tick(1'b1, tt, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic done_pulse();
      tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bus.trig_valid_i = 1'b0;
      bus.trig_time_i  = '0;
      bus.m_ready_i    = 1'b1;

      // Reset values
      rst_req = 1'b1; idle(3);
      rst_req = 1'b0; idle(2);
      check("rst_credits", credits, 4);
      check("rst_stopped", stopped, 1);
      check("rst_running", running, 0);
      check("rst_valid", bus.m_valid_o, 0);
      check("rst_drop", drop_count, 0);

      // First trigger: latency 1, event 0, one credit consumed
      tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      trig(16'h1234);                       // cycle t
      idle(1);
      check("s1_valid", bus.m_valid_o, 1);
      check("s1_time", bus.m_trig_time_o, 16'h1234);
      check("s1_event", bus.m_event_no_o, 0);
      check("s1_credits", credits, 3);
      check("s1_model_credits", m_credits, 3);

      // Holdoff: t+10 refused, t+32 accepted
      idle(8);
      trig(16'h0010);                       // t+10
      idle(21);
      trig(16'h0032);                       // t+32
      idle(1);
      check("s2_drop", drop_count, 1);
      check("s2_event", bus.m_event_no_o, 1);
      check("s2_time", bus.m_trig_time_o, 16'h0032);
      check("s2_credits", credits, 2);

      // Credit exhaustion after a run restart (counters cleared, credits kept)
      done_pulse(); done_pulse();
      tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      idle(40);
      for (int k = 0; k < 6; k++) begin
         trig(16'h3000 + 16'(k));
         idle(39);
      end
      check("s3_credits", credits, 0);
      check("s3_drop", drop_count, 2);
      check("s3_last_event", bus.m_event_no_o, 3);
      check("s3_model_drop", m_dc, 2);
      done_pulse();
      trig(16'h3100);
      idle(1);
      check("s3_event4", bus.m_event_no_o, 4);
      check("s3_credits_after", credits, 0);

      // Backpressure: held output blocks a spaced trigger; data stays put
      done_pulse(); done_pulse();
      rdy = 1'b0;
      idle(40);
      trig(16'hAAAA);
      idle(40);
      trig(16'hBBBB);
      idle(1);
      check("s4_valid_held", bus.m_valid_o, 1);
      check("s4_time_held", bus.m_trig_time_o, 16'hAAAA);
      check("s4_event_held", bus.m_event_no_o, 5);
      check("s4_drop", drop_count, 3);
      rdy = 1'b1;
      idle(1);
      idle(1);
      check("s4_valid_clear", bus.m_valid_o, 0);

      // Stop with two buffers outstanding, drain, then overflow error
      done_pulse();
      tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      idle(1);
      check("s5_running", running, 0);
      check("s5_state_drain", state_dbg, 2);
      trig(16'h5555);
      idle(1);
      check("s5_drop_drain", drop_count, 3);
      done_pulse(); done_pulse();
      idle(2);
      check("s5_stopped", stopped, 1);
      check("s5_credits_full", credits, 4);
      done_pulse();
      idle(1);
      check("s5_err", err, 1);
      check("s5_credits_same", credits, 4);
      trig(16'h5556);
      idle(1);
      check("s5_drop_idle", drop_count, 3);

      // Simultaneous run_rst and run_stop: stop wins, counters kept
      tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      trig(16'h0101);
      trig(16'h0202);
      tick(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      idle(1);
      check("s6_state_drain", state_dbg, 2);
      check("s6_drop_kept", drop_count, 1);
      tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      idle(1);
      check("s6_rst_ignored", state_dbg, 2);
      done_pulse();
      idle(2);
      check("s6_stopped", stopped, 1);

      // Reset mid-operation abandons a pending request
      tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      rdy = 1'b0;
      trig(16'h7777);
      idle(3);
      check("s7_pending", bus.m_valid_o, 1);
      rst_req = 1'b1; idle(1);
      rst_req = 1'b0; idle(1);
      check("s7_valid_abandoned", bus.m_valid_o, 0);
      check("s7_time_reset", bus.m_trig_time_o, 0);
      check("s7_err_cleared", err, 0);
      check("s7_credits", credits, 4);
      rdy = 1'b1;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
